rainbow_fader: RTL
==================

# rainbow_fader

Parametrised PWM rainbow-fade engine for the board RGB LED. It walks a six-segment hue wheel and drives three PWM channels from one shared timebase, with configurable PWM period, step size, step rate and output polarity. It adds run-time mode control (fade, hold, discrete step, off) and direction control. It sits directly under `top`, between the 12 MHz `clk` and the `RGB_R`/`RGB_G`/`RGB_B` pins.

## Interface
- `PWM_INTERVAL`, 1200: clock cycles per PWM period; also the full-scale duty value MAX.
- `STEP_SIZE`, 12: duty increment per step. Must divide `PWM_INTERVAL`; enforce with an elaboration-time check.
- `STEP_PERIODS`, 20: PWM periods per step event.
- `OUT_INVERT`, 1: 1 means active-low pins, so outputs are XORed with 1.
- CW: `$clog2(PWM_INTERVAL+1)`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `mode` in 2: 0 FADE, 1 HOLD, 2 STEP, 3 OFF.
- `dir` in 1: 0 forward (seg+), 1 reverse (seg−).
- `rgb_r`, `rgb_g`, `rgb_b` out 1: registered PWM outputs.
- `seg` out 3: current hue segment, 0..5.
- `period_tick` out 1: high for one cycle when `pwm_cnt == PWM_INTERVAL-1`.
- `step_tick` out 1: high together with every `STEP_PERIODS`-th `period_tick`.

## Operation
- `pwm_cnt` counts 0..MAX-1 and wraps to 0.
- `per_cnt` counts `period_tick`s 0..STEP_PERIODS-1. `step_tick` = `period_tick` && `per_cnt == STEP_PERIODS-1`.
- State is `seg` (0..5) and ramp `r` (0..MAX-STEP_SIZE, always a multiple of STEP_SIZE).
- Channel duty per segment (rise = r, fall = MAX−r):
  - seg0: R=MAX, G=rise, B=0
  - seg1: R=fall, G=MAX, B=0
  - seg2: R=0, G=MAX, B=rise
  - seg3: R=0, G=fall, B=MAX
  - seg4: R=rise, G=0, B=MAX
  - seg5: R=MAX, G=0, B=fall
- `mode` and `dir` are sampled only on `step_tick`. Update rules on `step_tick`:
  - FADE, forward: if `r+STEP_SIZE == MAX` then seg←(seg+1) mod 6, r←0; else r←r+STEP_SIZE.
  - FADE, reverse: if `r == 0` then seg←(seg+5) mod 6, r←MAX−STEP_SIZE; else r←r−STEP_SIZE.
  - STEP: seg←seg±1 mod 6 according to `dir`, r←0.
  - HOLD and OFF: state unchanged.
- Shadow duties (CW bits each) load on every `period_tick` from the pre-edge state. In OFF they load 0.
- Output: `rgb_x` ← (`pwm_cnt` < `duty_x`) ^ `OUT_INVERT`. Duty 0 gives never-on; duty MAX gives always-on.
- Leaving OFF resumes from the held `seg`/`r`.

## Timing
- Async reset clears `pwm_cnt`, `per_cnt`, `seg`, `r` and all shadow duties to 0. During reset:
  - `rgb_*` = `OUT_INVERT` (inactive level);
  - `period_tick` = `step_tick` = 0;
  - `seg` = 0.
- Reset asserted mid-period forces these values immediately, with no clock edge needed.
- First `period_tick` occurs at cycle MAX−1 after reset release. The first lit period (seg0: R full) starts at cycle MAX.
- Outputs are registered, so the pin lags the compare by 1 cycle. Duty changes occur only at period boundaries, which keeps the outputs glitch-free.
- A step's new colour appears in the period starting one full PWM period after the `step_tick` edge. This is because the shadow captures the pre-update state.
- Seg wrap: 5→0 going forward, 0→5 going reverse.
- Full forward hue cycle = 6·MAX/STEP_SIZE steps. With the defaults this is 600 steps × 20 × 1200 cycles ≈ 1.2 s at 12 MHz.

## Structure
- Package `rainbow_pkg`:
  - `mode_e` (FADE/HOLD/STEP/OFF);
  - `seg_t` (3 bits);
  - `NUM_SEGS` = 6;
  - a `seg_duty` function that maps (seg, r, MAX) to the three duties.
- Sub-module `pwm_channel`, instantiated three times: shadow duty register, compare against the shared `pwm_cnt`, inversion, output register.
- The timebase, step counter and hue state machine live in `rainbow_fader`.

## Test plan
All scenarios use `PWM_INTERVAL`=12, `STEP_SIZE`=4, `STEP_PERIODS`=2, `OUT_INVERT`=0.

1. **Reset release:** `rgb`=000 for cycles 0..12; `period_tick` at cycle 11; `seg`=0; from cycle 13, R high 12/12 cycles and G, B low.
2. **FADE forward:** G high-time per period steps 0, 4, 8 (each held 2 periods, shifted one period after `step_tick`). Then `seg`=1 with G=12 and R falling 12, 8, 4, 0.
3. **Wrap:** after 18 `step_tick`s `seg`=0 and r=0. Then set `dir`=1: next step gives `seg`=5, r=8, so R=12 and B=4.
4. **STEP mode:** `seg` goes 0→1→2 on successive `step_tick`s with r=0. Colours follow: R=12 and G=12, then G=12 with B=0.
5. **HOLD for 10 steps:** `seg` and duties unchanged. **OFF:** `rgb`=000 from the next period. **Back to FADE:** resumes from the same `seg`/`r`.
6. **Async reset mid-period with G high:** `rgb_g`=0 and `seg`=0 before the next `clk` edge; recovers as in scenario 1.

Source files
------------

// File: rtl/rainbow_pkg.sv
// ============================================================================
// rainbow_pkg : shared types and hue-wheel duty mapping for rainbow_fader
// Rev 1.0
// ============================================================================
`default_nettype none

package rainbow_pkg;

  typedef enum logic [1:0] {
    FADE = 2'd0,
    HOLD = 2'd1,
    STEP = 2'd2,
    OFF  = 2'd3
  } mode_e;

  typedef logic [2:0] seg_t;

  localparam int NUM_SEGS = 6;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
  } duty_t;

  // rise = ramp, fall = max - ramp; each segment fades exactly one channel
  function automatic duty_t seg_duty(input seg_t seg, input logic [31:0] ramp,
                                     input logic [31:0] max);
    duty_t       d;
    logic [31:0] rise;
    logic [31:0] fall;
    rise = ramp;
    fall = max - ramp;
    d    = '0;
    case (seg)
      3'd0: begin d.r = max;  d.g = rise; end
      3'd1: begin d.r = fall; d.g = max;  end
      3'd2: begin d.g = max;  d.b = rise; end
      3'd3: begin d.g = fall; d.b = max;  end
      3'd4: begin d.r = rise; d.b = max;  end
      3'd5: begin d.r = max;  d.b = fall; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rainbow_fader_pwm_channel.sv
// ============================================================================
// pwm_channel : shadowed duty register, compare against shared counter, output
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_channel #(
  parameter int CW         = 11,
  parameter bit OUT_INVERT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] duty_in,
  input  logic [CW-1:0] pwm_cnt,
  output logic          pwm_out
);

  logic [CW-1:0] duty_q, duty_d;
  logic          out_q, out_d;

  always_comb begin
    duty_d = load ? duty_in : duty_q;
    out_d  = (pwm_cnt < duty_q) ^ OUT_INVERT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
      out_q  <= OUT_INVERT;
    end else begin
      duty_q <= duty_d;
      out_q  <= out_d;
    end
  end

  assign pwm_out = out_q;

endmodule

`default_nettype wire

// File: rtl/rainbow_fader.sv
// ============================================================================
// rainbow_fader : PWM timebase, step counter and hue-wheel state for the RGB LED
// Rev 1.0
// ============================================================================
`default_nettype none

module rainbow_fader
  import rainbow_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEP_SIZE    = 12,
  parameter int STEP_PERIODS = 20,
  parameter bit OUT_INVERT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       dir,
  output logic       rgb_r,
  output logic       rgb_g,
  output logic       rgb_b,
  output logic [2:0] seg,
  output logic       period_tick,
  output logic       step_tick
);

  localparam int CW = $clog2(PWM_INTERVAL + 1);
  localparam int PW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [CW-1:0] DUTY_MAX = CW'(PWM_INTERVAL);
  localparam logic [CW-1:0] STEP_INC = CW'(STEP_SIZE);
  localparam logic [CW-1:0] RAMP_TOP = CW'(PWM_INTERVAL - STEP_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_INTERVAL - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(STEP_PERIODS - 1);
  localparam seg_t          SEG_LAST = seg_t'(NUM_SEGS - 1);

  generate
    if ((PWM_INTERVAL % STEP_SIZE) != 0) begin : g_step_check
      $error("rainbow_fader: STEP_SIZE must divide PWM_INTERVAL");
    end
  endgenerate

  logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  seg_t          seg_q, seg_d;
  logic [CW-1:0] r_q, r_d;
  mode_e         mode_q, mode_d;
  mode_e         mode_in;
  logic          period_tick_w, step_tick_w;

  assign mode_in       = mode_e'(mode);
  assign period_tick_w = (pwm_cnt_q == CNT_LAST);
  assign step_tick_w   = period_tick_w && (per_cnt_q == PER_LAST);

  always_comb begin
    pwm_cnt_d = period_tick_w ? '0 : pwm_cnt_q + 1'b1;
    per_cnt_d = per_cnt_q;
    if (period_tick_w) per_cnt_d = step_tick_w ? '0 : per_cnt_q + 1'b1;

    seg_d  = seg_q;
    r_d    = r_q;
    mode_d = mode_q;
    if (step_tick_w) begin
      mode_d = mode_in;
      case (mode_in)
        FADE: begin
          if (!dir) begin
            if (r_q + STEP_INC == DUTY_MAX) begin
              seg_d = (seg_q == SEG_LAST) ? '0 : seg_q + 1'b1;
              r_d   = '0;
            end else begin
              r_d = r_q + STEP_INC;
            end
          end else begin
            if (r_q == '0) begin
              seg_d = (seg_q == '0) ? SEG_LAST : seg_q - 1'b1;
              r_d   = RAMP_TOP;
            end else begin
              r_d = r_q - STEP_INC;
            end
          end
        end
        STEP: begin
          if (!dir) seg_d = (seg_q == SEG_LAST) ? '0 : seg_q + 1'b1;
          else      seg_d = (seg_q == '0) ? SEG_LAST : seg_q - 1'b1;
          r_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      per_cnt_q <= '0;
      seg_q     <= '0;
      r_q       <= '0;
      mode_q    <= FADE;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      per_cnt_q <= per_cnt_d;
      seg_q     <= seg_d;
      r_q       <= r_d;
      mode_q    <= mode_d;
    end
  end

  // Shadows capture the pre-update state, so a step shows one period later
  duty_t         duty_w;
  logic [CW-1:0] duty_ch [3];
  logic [2:0]    pwm_out;
  logic          unused_duty_bits;

  assign duty_w     = seg_duty(seg_q, 32'(r_q), 32'(PWM_INTERVAL));
  assign duty_ch[0] = (mode_q == OFF) ? '0 : duty_w.r[CW-1:0];
  assign duty_ch[1] = (mode_q == OFF) ? '0 : duty_w.g[CW-1:0];
  assign duty_ch[2] = (mode_q == OFF) ? '0 : duty_w.b[CW-1:0];
  assign unused_duty_bits = ^{duty_w.r[31:CW], duty_w.g[31:CW], duty_w.b[31:CW]};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_channel
      pwm_channel #(
        .CW        (CW),
        .OUT_INVERT(OUT_INVERT)
      ) u_pwm_channel (
        .clk    (clk),
        .rst    (rst),
        .load   (period_tick_w),
        .duty_in(duty_ch[i]),
        .pwm_cnt(pwm_cnt_q),
        .pwm_out(pwm_out[i])
      );
    end
  endgenerate

  assign rgb_r       = pwm_out[0];
  assign rgb_g       = pwm_out[1];
  assign rgb_b       = pwm_out[2];
  assign seg         = seg_q;
  assign period_tick = period_tick_w;
  assign step_tick   = step_tick_w;

endmodule

`default_nettype wire
